arf_stack_sequencer: RTL
========================

Name: arf_stack_sequencer

Overview:
- Command-driven sequencer for the PC/SP/AR address register file (ARF).
- Turns single-word commands (FETCH, PUSH, POP, CALL, RET, JUMP, SPINIT) into timed sequences of ARF RegSel/FunSel/OutCSel/OutDSel/input drives plus memory strobes.
- Tracks stack depth and flags overflow/underflow.
- ARF OutD is wired externally as the memory address; ARF outputs are registered, one cycle after select.

Parameters:
- STACK_BASE, 16'hFF00, SP value for an empty stack (full-descending: push decrements, then writes).
- DEPTH, 64, maximum stack entries.
- RESET_VECTOR, 16'h0000, PC value loaded after reset.
- TIMEOUT, 15, memory wait limit in cycles (only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  000 FETCH, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 JUMP, 110 SPINIT, 111 reserved.
- cmd_addr  in  16  target for CALL/JUMP.
- cmd_data  in  16  PUSH data.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_data  out  16  FETCH/POP data, old PC for CALL, else 0.
- rsp_err  out  1  qualified by rsp_valid.
- arf_regsel  out  3  {PC,SP,AR} enables.
- arf_funsel  out  2  00 DEC, 01 INC, 10 LOAD, 11 CLEAR.
- arf_outcsel  out  2  00 PC, 01 SP, 10 AR.
- arf_outdsel  out  2  same encoding.
- arf_i  out  32  ARF load value, [31:16]=0.
- arf_outc  in  16  ARF OutC.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_wdata  out  16  write data.
- mem_ready  in  1  access completes in a cycle where a strobe and mem_ready are both high.
- mem_rdata  in  16  valid when mem_ready is high.
- stack_depth  out  7  current entries, 0..DEPTH.

Behaviour:
- Reset (async): state INIT_PC, depth 0, all outputs 0; any in-flight memory strobe drops immediately.
- After reset release:
  - INIT_PC: regsel=100, funsel=LOAD, arf_i=RESET_VECTOR.
  - INIT_SP: regsel=010, LOAD, arf_i=STACK_BASE.
  - Then IDLE; cmd_ready first high in the 3rd cycle after release.
- Handshake: command accepted when cmd_valid && cmd_ready; cmd_op/addr/data are latched at acceptance.
- regsel is non-zero only in UPD/LD/INIT states, for exactly one cycle each.
- Memory access (MEM state):
  - Always preceded by a SELD cycle: outdsel set in SELD and held through MEM, so the address is valid in MEM.
  - MEM holds the strobe until mem_ready; mem_rdata is latched on the mem_ready cycle.
- Sequences (UPD = INC/DEC pulse, LD = LOAD pulse, RSP = rsp_valid cycle):
  - FETCH: SELD(PC), MEM rd, UPD PC INC, RSP.
  - PUSH: UPD SP DEC, SELD(SP), MEM wr cmd_data, RSP; depth+1.
  - POP: SELD(SP), MEM rd, UPD SP INC, RSP; depth-1.
  - CALL: outcsel=PC held from accept; UPD SP DEC, SELD(SP), MEM wr arf_outc, LD PC cmd_addr, RSP; depth+1.
  - RET: SELD(SP), MEM rd, LD PC rdata, UPD SP INC, RSP; depth-1.
  - JUMP: LD PC cmd_addr, RSP.
  - SPINIT: LD SP STACK_BASE, RSP; depth=0.
- Latency with mem_ready tied high, counted from the accept edge:
  - FETCH/POP/PUSH: rsp_valid in cycle 4.
  - CALL/RET: cycle 5.
  - JUMP/SPINIT: cycle 2.
- Each mem_ready wait cycle adds one cycle of latency.
- Errors:
  - PUSH/CALL at depth==DEPTH, POP/RET at depth==0, or op 111: IDLE goes straight to RSP with rsp_err=1.
  - rsp_valid is in cycle 1; no ARF or memory activity; depth unchanged.
- Depth updates in the RSP cycle, never wraps. SP arithmetic is 16-bit wrap, as done by the ARF.
- Reset mid-operation: sequence aborted, partial SP/PC effects stand, INIT rerun, depth 0 (software re-runs SPINIT if needed).

Optional Feature:
- Macro: ARF_MEM_TIMEOUT_EN.
- Defined:
  - A counter in MEM aborts the access after TIMEOUT cycles without mem_ready.
  - Strobe drops; go to RSP with rsp_err=1.
  - Skip remaining UPD/LD steps; depth unchanged.
  - A prior SP DEC (PUSH/CALL) is undone by one UPD SP INC before RSP.
- Undefined: MEM waits indefinitely.

Test Plan:
- Release reset → regsel 100 then 010 with LOAD; PC=0000, SP=FF00; cmd_ready high in cycle 3; stack_depth=0.
- FETCH, PC=0000, mem_rdata=A5A5, mem_ready=1 → mem_rd at addr 0000, rsp_data=A5A5 in cycle 4, PC=0001.
- PUSH 1234 → mem_wr addr FEFF data 1234, depth 1; POP → rsp_data=1234, SP=FF00, depth 0.
- PC=0005, CALL 0040 → write 0005 at FEFF, PC=0040, rsp_data=0005; RET → PC=0005, SP=FF00.
- POP at depth 0 → rsp_err=1 in cycle 1, no strobes; 64 PUSHes OK, 65th → rsp_err, SP=FEC0.
- FETCH with mem_ready low 3 cycles → rsp in cycle 7; repeat and assert reset mid-wait → mem_rd=0 immediately, INIT rerun. With macro: ready held low 15 cycles → rsp_err=1.

Source files
------------

// File: rtl/arf_stack_sequencer.sv
// Command sequencer driving the PC/SP/AR address register file and memory strobes.
// Optional memory-access timeout is enabled with `define ARF_MEM_TIMEOUT_EN.
`timescale 1ns/1ps
module arf_stack_sequencer #(
  parameter logic [15:0] STACK_BASE   = 16'hFF00,
  parameter int unsigned DEPTH        = 64,
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  arf_regsel,
  output logic [1:0]  arf_funsel,
  output logic [1:0]  arf_outcsel,
  output logic [1:0]  arf_outdsel,
  output logic [31:0] arf_i,
  input  logic [15:0] arf_outc,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [6:0]  stack_depth,
  output logic [3:0]  dbg_state
);

  localparam logic [3:0] S_INIT_PC  = 4'd0;
  localparam logic [3:0] S_INIT_SP  = 4'd1;
  localparam logic [3:0] S_IDLE     = 4'd2;
  localparam logic [3:0] S_UPD_PRE  = 4'd3;
  localparam logic [3:0] S_SELD     = 4'd4;
  localparam logic [3:0] S_MEM      = 4'd5;
  localparam logic [3:0] S_LD       = 4'd6;
  localparam logic [3:0] S_UPD_POST = 4'd7;
  localparam logic [3:0] S_RSP      = 4'd8;
  localparam logic [3:0] S_UNDO     = 4'd9;

  localparam logic [2:0] OP_FETCH  = 3'b000;
  localparam logic [2:0] OP_PUSH   = 3'b001;
  localparam logic [2:0] OP_POP    = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;
  localparam logic [2:0] OP_JUMP   = 3'b101;
  localparam logic [2:0] OP_SPINIT = 3'b110;

  localparam logic [1:0] F_DEC  = 2'b00;
  localparam logic [1:0] F_INC  = 2'b01;
  localparam logic [1:0] F_LOAD = 2'b10;

  localparam logic [6:0] DEPTH_MAX = 7'(DEPTH);

  logic [3:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [6:0]  depth_q, depth_d;
  logic        cmd_err;
  logic        wr_op;
  logic        mem_abort;
  logic [15:0] arf_lo;

  assign wr_op = (op_q == OP_PUSH) || (op_q == OP_CALL);

  assign cmd_err = (((cmd_op == OP_PUSH) || (cmd_op == OP_CALL)) && (depth_q == DEPTH_MAX)) ||
                   (((cmd_op == OP_POP)  || (cmd_op == OP_RET))  && (depth_q == 7'd0)) ||
                   (cmd_op == 3'b111);

`ifdef ARF_MEM_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  assign tmo_d     = ((state_q == S_MEM) && !mem_ready) ? tmo_q + 8'd1 : 8'd0;
  assign mem_abort = (state_q == S_MEM) && !mem_ready && (tmo_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tmo_q <= 8'd0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
  assign mem_abort  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    depth_d = depth_q;
    case (state_q)
      S_INIT_PC: state_d = S_INIT_SP;
      S_INIT_SP: state_d = S_IDLE;
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          rdata_d = 16'h0000;
          err_d   = cmd_err;
          if (cmd_err) state_d = S_RSP;
          else begin
            case (cmd_op)
              OP_FETCH, OP_POP, OP_RET: state_d = S_SELD;
              OP_PUSH, OP_CALL:         state_d = S_UPD_PRE;
              default:                  state_d = S_LD;
            endcase
          end
        end
      end
      S_UPD_PRE: state_d = S_SELD;
      S_SELD:    state_d = S_MEM;
      S_MEM: begin
        if (mem_ready) begin
          // CALL reports the PC it pushed, which is what OutC shows here.
          rdata_d = (op_q == OP_CALL) ? arf_outc : mem_rdata;
          case (op_q)
            OP_FETCH, OP_POP: state_d = S_UPD_POST;
            OP_PUSH:          state_d = S_RSP;
            default:          state_d = S_LD;
          endcase
        end else if (mem_abort) begin
          err_d   = 1'b1;
          state_d = wr_op ? S_UNDO : S_RSP;
        end
      end
      S_LD:       state_d = (op_q == OP_RET) ? S_UPD_POST : S_RSP;
      S_UPD_POST: state_d = S_RSP;
      S_UNDO:     state_d = S_RSP;
      S_RSP: begin
        state_d = S_IDLE;
        if (!err_q) begin
          case (op_q)
            OP_PUSH, OP_CALL: depth_d = depth_q + 7'd1;
            OP_POP, OP_RET:   depth_d = depth_q - 7'd1;
            OP_SPINIT:        depth_d = 7'd0;
            default:          depth_d = depth_q;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT_PC;
      op_q    <= 3'd0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      depth_q <= 7'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      depth_q <= depth_d;
    end
  end

  // Register-file drives are held off while reset is asserted so every output reads 0.
  always_comb begin
    arf_regsel = 3'b000;
    arf_funsel = 2'b00;
    arf_lo     = 16'h0000;
    if (!reset) begin
      case (state_q)
        S_INIT_PC: begin arf_regsel = 3'b100; arf_funsel = F_LOAD; arf_lo = RESET_VECTOR; end
        S_INIT_SP: begin arf_regsel = 3'b010; arf_funsel = F_LOAD; arf_lo = STACK_BASE;   end
        S_UPD_PRE: begin arf_regsel = 3'b010; arf_funsel = F_DEC; end
        S_UNDO:    begin arf_regsel = 3'b010; arf_funsel = F_INC; end
        S_UPD_POST: begin
          arf_regsel = (op_q == OP_FETCH) ? 3'b100 : 3'b010;
          arf_funsel = F_INC;
        end
        S_LD: begin
          arf_funsel = F_LOAD;
          if (op_q == OP_SPINIT) begin
            arf_regsel = 3'b010;
            arf_lo     = STACK_BASE;
          end else begin
            arf_regsel = 3'b100;
            arf_lo     = (op_q == OP_RET) ? rdata_q : addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign arf_i = {16'h0000, arf_lo};

  // OutC only ever has to present the PC (for CALL), so it stays on PC.
  assign arf_outcsel = 2'b00;
  assign arf_outdsel = (((state_q == S_SELD) || (state_q == S_MEM)) && (op_q != OP_FETCH)) ? 2'b01 : 2'b00;

  assign mem_rd    = (state_q == S_MEM) && !wr_op;
  assign mem_wr    = (state_q == S_MEM) && wr_op;
  assign mem_wdata = mem_wr ? ((op_q == OP_CALL) ? arf_outc : data_q) : 16'h0000;

  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RSP);
  assign rsp_err     = (state_q == S_RSP) && err_q;
  assign rsp_data    = ((state_q == S_RSP) && !err_q &&
                        ((op_q == OP_FETCH) || (op_q == OP_POP) || (op_q == OP_CALL))) ? rdata_q : 16'h0000;
  assign stack_depth = depth_q;
  assign dbg_state   = state_q;

endmodule
